// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle between the stimulus side and the bit-serial adder sequencer.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving a single gate-level full adder, LSB first.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, a_sh_nxt;
    logic [WIDTH-1:0] b_sh, b_sh_nxt;
    logic [WIDTH-1:0] sum_sh, sum_sh_nxt;
    logic [WIDTH-1:0] sum_q, sum_nxt;
    logic             carry, carry_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             cout_q, cout_nxt;
    logic             ovf_q, ovf_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             fa_s, fa_co;
    logic             last_bit;

    fullAdderGL u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last_bit = (count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values; results land on the final RUN edge so they are valid in DONE
    always_comb begin
        a_sh_nxt   = a_sh;
        b_sh_nxt   = b_sh;
        sum_sh_nxt = sum_sh;
        carry_nxt  = carry;
        count_nxt  = count;
        sum_nxt    = sum_q;
        cout_nxt   = cout_q;
        ovf_nxt    = ovf_q;
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state_nxt == DONE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_sh_nxt   = bus.a;
                    b_sh_nxt   = bus.sub ? ~bus.b : bus.b;
                    carry_nxt  = bus.sub | bus.cin;
                    count_nxt  = '0;
                    sum_sh_nxt = '0;
                end
            end
            RUN: begin
                a_sh_nxt   = a_sh >> 1;
                b_sh_nxt   = b_sh >> 1;
                sum_sh_nxt = {fa_s, sum_sh[WIDTH-1:1]};
                carry_nxt  = fa_co;
                if (last_bit) begin
                    sum_nxt  = {fa_s, sum_sh[WIDTH-1:1]};
                    cout_nxt = fa_co;
                    ovf_nxt  = carry ^ fa_co;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_sh   <= a_sh_nxt;
            b_sh   <= b_sh_nxt;
            sum_sh <= sum_sh_nxt;
            carry  <= carry_nxt;
            count  <= count_nxt;
            sum_q  <= sum_nxt;
            cout_q <= cout_nxt;
            ovf_q  <= ovf_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// Gate-level full adder cell shared by the sequencer.
module fullAdderGL (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic axb, g, p;

    xor x0 (axb, a, b);
    xor x1 (s, axb, cin);
    and a0 (g, a, b);
    and a1 (p, axb, cin);
    or  o0 (cout, g, p);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: scoreboarded results, cycle-exact busy/done timing.
module tb_serial_adder_ctrl;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t last;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input logic c);
        logic [WIDTH:0] f;
        exp_t e;
        if (s) f = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   f = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
        e.sum  = f[WIDTH-1:0];
        e.cout = f[WIDTH];
        if (s) e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
        else   e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Caller sits at a negedge with the DUT idle; returns at the negedge of cycle k+WIDTH+2.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic isub, input logic icin, input exp_t e, input bit noise);
        exp_t got;
        sb.push_back(e);
        bus.a = ia; bus.b = ib; bus.sub = isub; bus.cin = icin; bus.start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= int'(WIDTH) + 1; n++) begin
            bus.start = 1'b0;
            bus.a   = WIDTH'($urandom);
            bus.b   = WIDTH'($urandom);
            bus.sub = 1'($urandom);
            bus.cin = 1'($urandom);
            check("busy_run", 32'(bus.busy), 32'd1);
            check("done_timing", 32'(bus.done), 32'(n == int'(WIDTH) + 1));
            if (n == 1) check("sum_hold_inflight", 32'(bus.sum), 32'(last.sum));
            if (n == int'(WIDTH) + 1) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("sum", 32'(bus.sum), 32'(got.sum));
                    check("cout", 32'(bus.cout), 32'(got.cout));
                    check("ovf", 32'(bus.ovf), 32'(got.ovf));
                    last = got;
                end
            end
            if (noise && (n == 3 || n == int'(WIDTH) + 1)) begin
                bus.start = 1'b1;
                bus.a = 8'hC3; bus.b = 8'h3C; bus.sub = 1'b0; bus.cin = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_after", 32'(bus.busy), 32'd0);
        check("done_after", 32'(bus.done), 32'd0);
        check("sum_after", 32'(bus.sum), 32'(last.sum));
    endtask

    initial begin
        exp_t e;
        logic [WIDTH-1:0] ra, rb;
        logic rs, rc;
        checks = 0; failures = 0;
        last = '{sum: '0, cout: 1'b0, ovf: 1'b0};
        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases with hand-computed results
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, '{sum: 8'h8D, cout: 1'b0, ovf: 1'b1}, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0}, 1'b0);
        run_op(8'h7F, 8'h00, 1'b0, 1'b1, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1}, 1'b0);
        run_op(8'h10, 8'h20, 1'b1, 1'b1, '{sum: 8'hF0, cout: 1'b0, ovf: 1'b0}, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1'b0, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1}, 1'b0);

        // Starts while busy (including DONE) are ignored; immediate restart is accepted
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, '{sum: 8'h8D, cout: 1'b0, ovf: 1'b1}, 1'b1);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, '{sum: 8'h03, cout: 1'b0, ovf: 1'b0}, 1'b0);

        // Reset mid-operation abandons the result
        bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        check("midrst_ovf", 32'(bus.ovf), 32'd0);
        last = '{sum: '0, cout: 1'b0, ovf: 1'b0};
        for (int i = 0; i < int'(WIDTH) + 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(bus.done), 32'd0);
        end
        run_op(8'h7E, 8'h05, 1'b1, 1'b0, model(8'h7E, 8'h05, 1'b1, 1'b0), 1'b0);

        // start together with rst in IDLE stays idle
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        last = '{sum: '0, cout: 1'b0, ovf: 1'b0};
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("rst_start_busy2", 32'(bus.busy), 32'd0);
        check("rst_start_done", 32'(bus.done), 32'd0);

        // Randomised operations against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rs = 1'($urandom);     rc = 1'($urandom);
            e  = model(ra, rb, rs, rc);
            run_op(ra, rb, rs, rc, e, 1'b0);
        end

        // Results hold while inputs wander with start low
        for (int i = 0; i < 10; i++) begin
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
            @(negedge clk);
            check("hold_sum", 32'(bus.sum), 32'(last.sum));
            check("hold_cout", 32'(bus.cout), 32'(last.cout));
            check("hold_ovf", 32'(bus.ovf), 32'(last.ovf));
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
